fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and instruction-fetch stage sitting directly upstream of the control decoder. It holds the PC, drives the instruction-memory address, and sequences a run with a start/done handshake. It takes the decoder's `Branch` and `how_high` outputs back to compute the next PC through a fixed branch-offset lookup table.

## Interface
Parameters:
- `PC_W`, 10: PC / instruction-memory address width.
- `OFF_W`, 8: width of signed branch offsets held in the lookup table.

Ports:
- `clk`  in  1: the single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle pulse that begins (or restarts) execution at PC 0.
- `stall`  in  1: holds the PC and state for the cycle.
- `prog_end`  in  PC_W: address of the last instruction of the program; static while running.
- `branch`  in  1: branch taken, from the decoder `Branch` output (already zero-qualified).
- `how_high`  in  2: branch-table index, from the decoder.
- `imem_addr`  out  PC_W: current PC, registered; drives instruction memory.
- `fetch_valid`  out  1: the instruction at `imem_addr` executes this cycle.
- `done`  out  1: program completed; high while in DONE.
- `retired`  out  16: retired-instruction count; present only with `FETCH_RETIRE_CNT_EN`.

## Operation
- States: IDLE, RUN, DONE. The state is registered; outputs are decoded from the state and the PC only.
- IDLE:
  - `fetch_valid`=0, `done`=0, PC held at 0.
  - `start` moves to RUN with PC=0.
- RUN:
  - `fetch_valid`=1.
  - `stall`=1: PC and state hold; `branch` is ignored.
  - Otherwise, if PC == `prog_end`: move to DONE, PC holds. `branch` is ignored for this last instruction.
  - Otherwise, `branch`=1: PC <= PC + sext(BR_OFFSET[how_high]).
  - Otherwise: PC <= PC + 1.
- DONE:
  - `done`=1, `fetch_valid`=0, PC holds.
  - `start` moves to RUN with PC=0 and clears `done`.
- `start` in RUN restarts: PC <= 0 on the next edge, state stays RUN. `start` overrides `stall` and branch.
- Arithmetic: the offset is sign-extended from OFF_W to PC_W. The sum is taken modulo 2^PC_W; wrap-around is silent and legal.
- `branch` and `how_high` are don't-care whenever `fetch_valid`=0.

## Timing
- Reset (async assert): state IDLE, PC 0, `imem_addr`=0, `fetch_valid`=0, `done`=0, `retired`=0. Reset applies immediately, mid-run included.
- Reset release: the first rising edge after deassertion behaves as IDLE.
- Start latency: `start` high at edge N gives `fetch_valid`=1 and `imem_addr`=0 after edge N.
- Next PC: one cycle per non-stalled RUN cycle. The branch is resolved in the same cycle the decoder sees the instruction, with zero bubbles.
- Completion: the instruction at `prog_end` executes in the cycle before `done` rises.
- `prog_end`=0: exactly one instruction executes, then DONE.

## Configuration
- `FETCH_RETIRE_CNT_EN` defined:
  - `retired` port exists.
  - The 16-bit counter increments on each RUN cycle with `stall`=0, including the final instruction.
  - It is cleared to 0 by reset and by an accepted `start`, and saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - the `fetch_state_t` enum (IDLE, RUN, DONE);
  - the `BR_OFFSET` constant array of 4 signed OFF_W values: index 0 = -4, 1 = -8, 2 = +6, 3 = +16;
  - the default `PC_W`.
- One sub-module, `branch_target`: combinational PC + sext(offset) adder with the table lookup. It is instantiated once; the FSM and PC register live in `fetch_unit`.

## Test plan
- Reset mid-run at PC=37 -> `imem_addr`=0, `fetch_valid`=0, `done`=0 immediately, without waiting for a clock edge.
- `prog_end`=5, no branches, pulse `start` -> `imem_addr` 0,1,2,3,4,5 on consecutive cycles; `done`=1 the following cycle; `retired`=6.
- PC=10, `branch`=1, `how_high`=01 -> next PC 2. PC=2, `how_high`=10 -> next PC 8.
- PC=2, `branch`=1, `how_high`=00, PC_W=10 -> next PC 1022 (wrap).
- `stall`=1 held 3 cycles at PC=4 with `branch`=1 -> PC stays 4 and `retired` unchanged. On release, the branch is taken.
- `start` pulsed in RUN at PC=7, and again in DONE -> PC=0 next cycle in both cases; `done` clears; `retired` resets to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// default widths and the fixed branch-offset lookup table.
package fetch_pkg;

   localparam int unsigned PC_W_DEFAULT  = 10;
   localparam int unsigned OFF_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fetch_state_t;

   // Indexed by the decoder's how_high field.
   localparam logic signed [OFF_W_DEFAULT-1:0] BR_OFFSET [4] = '{
      -8'sd4, -8'sd8, 8'sd6, 8'sd16
   };

endpackage

// File: rtl/branch_target.sv
// Branch target adder: PC plus the sign-extended table offset selected by
// how_high, wrapping modulo 2^PC_W.
module branch_target
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEFAULT,
   parameter int unsigned OFF_W = OFF_W_DEFAULT
) (
   input  logic [PC_W-1:0] pc,
   input  logic [1:0]      how_high,
   output logic [PC_W-1:0] target
);

   logic signed [OFF_W-1:0] off;
   logic signed [PC_W-1:0]  off_ext;

   always_comb begin
      off     = OFF_W'(BR_OFFSET[how_high]);
      off_ext = PC_W'(off);
      target  = pc + off_ext;
   end

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage with start/done run sequencing.
// Optional retired-instruction counter enabled by FETCH_RETIRE_CNT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEFAULT,
   parameter int unsigned OFF_W = OFF_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stall,
   input  logic [PC_W-1:0] prog_end,
   input  logic            branch,
   input  logic [1:0]      how_high,
   output logic [PC_W-1:0] imem_addr,
   output logic            fetch_valid,
   output logic            done
`ifdef FETCH_RETIRE_CNT_EN
   ,
   output logic [15:0]     retired
`endif
);

   fetch_state_t    state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [PC_W-1:0] br_target;

   branch_target #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_branch_target (
      .pc       (pc),
      .how_high (how_high),
      .target   (br_target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // start wins over stall and branch in every state.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      if (start) begin
         state_nxt = RUN;
         pc_nxt    = '0;
      end else begin
         unique case (state)
            IDLE: pc_nxt = '0;
            RUN: begin
               if (!stall) begin
                  if (pc == prog_end) state_nxt = DONE;
                  else if (branch)    pc_nxt    = br_target;
                  else                pc_nxt    = pc + 1'b1;
               end
            end
            DONE: ;
            default: begin
               state_nxt = IDLE;
               pc_nxt    = '0;
            end
         endcase
      end
   end

   always_comb begin
      imem_addr   = pc;
      fetch_valid = (state == RUN);
      done        = (state == DONE);
   end

`ifdef FETCH_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired <= '0;
      else if (start)
         retired <= '0;
      else if (state == RUN && !stall && retired != '1)
         retired <= retired + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random
// stimulus compared against a behavioural PC/run model.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stall, branch;
   logic [1:0] how_high;
   logic [9:0] prog_end;
   logic [9:0] imem_addr;
   logic       fetch_valid, done;
`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0] retired;
`endif

   int tests = 0;
   int fails = 0;

   // Behavioural model
   bit m_run, m_done;
   int m_pc, m_ret;
   int br_tab [4] = '{-4, -8, 6, 16};

   always #5 clk = ~clk;

   fetch_unit #(.PC_W(10), .OFF_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stall       (stall),
      .prog_end    (prog_end),
      .branch      (branch),
      .how_high    (how_high),
      .imem_addr   (imem_addr),
      .fetch_valid (fetch_valid),
      .done        (done)
`ifdef FETCH_RETIRE_CNT_EN
      ,
      .retired     (retired)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run  = 0;
      m_done = 0;
      m_pc   = 0;
      m_ret  = 0;
   endtask

   task automatic model_step(input bit s, input bit st, input bit br, input int hh);
      if (s) begin
         m_run = 1; m_done = 0; m_pc = 0; m_ret = 0;
      end else if (m_run && !st) begin
         if (m_ret < 65535) m_ret++;
         if (m_pc == int'(prog_end)) begin
            m_run = 0; m_done = 1;
         end else if (br)
            m_pc = (m_pc + br_tab[hh] + 1024) % 1024;
         else
            m_pc = (m_pc + 1) % 1024;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".addr"},  32'(imem_addr),   32'(m_pc));
      chk({tag, ".valid"}, 32'(fetch_valid), 32'(m_run));
      chk({tag, ".done"},  32'(done),        32'(m_done));
`ifdef FETCH_RETIRE_CNT_EN
      chk({tag, ".retired"}, 32'(retired), 32'(m_ret));
`endif
   endtask

   task automatic step(input bit s, input bit st, input bit br, input logic [1:0] hh,
                       input string tag = "step");
      start = s; stall = st; branch = br; how_high = hh;
      @(posedge clk);
      model_step(s, st, br, int'(hh));
      #1;
      check_all(tag);
   endtask

   task automatic go_pc(input int target);
      for (int k = 0; k < 1100 && m_run && m_pc != target; k++)
         step(1'b0, 1'b0, 1'b0, 2'd0, "walk");
      chk("go_pc_reached", 32'(m_pc), 32'(target));
   endtask

   initial begin
      int saved_ret;
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0;
      how_high = 2'd0; prog_end = 10'd5;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk) rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b1, 2'd3, "idle");

      // Straight-line program ending at 5
      step(1'b1, 1'b0, 1'b0, 2'd0, "start");
      chk("start_addr", 32'(imem_addr), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 2'd0, "seq");
         chk("seq_addr", 32'(imem_addr), 32'(i));
      end
      chk("last_valid", 32'(fetch_valid), 32'd1);
      step(1'b0, 1'b0, 1'b1, 2'd1, "finish");
      chk("done_set", 32'(done), 32'd1);
      chk("done_pc", 32'(imem_addr), 32'd5);
`ifdef FETCH_RETIRE_CNT_EN
      chk("retired_6", 32'(retired), 32'd6);
`endif
      step(1'b0, 1'b0, 1'b0, 2'd0, "done_hold");

      // Branch offsets
      prog_end = 10'd200;
      step(1'b1, 1'b0, 1'b0, 2'd0, "restart");
      go_pc(10);
      step(1'b0, 1'b0, 1'b1, 2'd1, "br_m8");
      chk("br_10_to_2", 32'(imem_addr), 32'd2);
      step(1'b0, 1'b0, 1'b1, 2'd2, "br_p6");
      chk("br_2_to_8", 32'(imem_addr), 32'd8);

      // Wrap-around
      step(1'b1, 1'b0, 1'b0, 2'd0, "restart");
      go_pc(2);
      step(1'b0, 1'b0, 1'b1, 2'd0, "br_wrap");
      chk("br_wrap_1022", 32'(imem_addr), 32'd1022);

      // Stall holds PC and counter; branch taken on release
      step(1'b1, 1'b0, 1'b0, 2'd0, "restart");
      go_pc(4);
      saved_ret = m_ret;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 2'd3, "stall");
         chk("stall_pc", 32'(imem_addr), 32'd4);
`ifdef FETCH_RETIRE_CNT_EN
         chk("stall_retired", 32'(retired), 32'(saved_ret));
`endif
      end
      step(1'b0, 1'b0, 1'b1, 2'd3, "stall_rel");
      chk("stall_rel_pc", 32'(imem_addr), 32'd20);

      // Restart in RUN (start beats stall and branch), then in DONE
      step(1'b1, 1'b0, 1'b0, 2'd0, "restart");
      go_pc(7);
      step(1'b1, 1'b1, 1'b1, 2'd2, "restart_run");
      chk("restart_run_pc", 32'(imem_addr), 32'd0);
      chk("restart_run_valid", 32'(fetch_valid), 32'd1);
      go_pc(200);
      step(1'b0, 1'b0, 1'b0, 2'd0, "to_done");
      chk("to_done", 32'(done), 32'd1);
      step(1'b1, 1'b0, 1'b0, 2'd0, "restart_done");
      chk("restart_done_pc", 32'(imem_addr), 32'd0);
      chk("restart_done_clr", 32'(done), 32'd0);
`ifdef FETCH_RETIRE_CNT_EN
      chk("restart_done_ret", 32'(retired), 32'd0);
`endif

      // Asynchronous reset mid-run
      go_pc(37);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_addr", 32'(imem_addr), 32'd0);
      chk("async_rst_valid", 32'(fetch_valid), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      check_all("async_rst");
      #10;
      @(negedge clk) rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 2'd0, "post_rst");

      // Single-instruction program
      prog_end = 10'd0;
      step(1'b1, 1'b0, 1'b1, 2'd3, "pe0_start");
      step(1'b0, 1'b0, 1'b1, 2'd3, "pe0_end");
      chk("pe0_done", 32'(done), 32'd1);
      chk("pe0_pc", 32'(imem_addr), 32'd0);

      // Random phase
      for (int i = 0; i < 2000; i++) begin
         bit s, st, br;
         s  = ($urandom_range(0, 63) == 0) || (!m_run && $urandom_range(0, 3) == 0);
         st = ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 9) < 3);
         if (s && !m_run) prog_end = 10'($urandom_range(0, 60));
         step(s, st, br, 2'($urandom_range(0, 3)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
